// File: rtl/program_sequencer.sv
// Program sequencer: fetch/load/exec control, PC and return-address stack.
// Define STACK_OVF_TRAP_EN to trap stack overflow/underflow into HALT.
module program_sequencer #(
    parameter int ADDR_WIDTH  = 8,
    parameter int INSTR_WIDTH = 5,
    parameter int OPND_WIDTH  = ADDR_WIDTH,
    parameter int STACK_DEPTH = 4
) (
    input  logic                              CLK,
    input  logic                              nRST,
    output logic [ADDR_WIDTH-1:0]             PROG_ADDR,
    output logic                              PROG_RE,
    input  logic [INSTR_WIDTH+OPND_WIDTH-1:0] PROG_DATA,
    output logic [INSTR_WIDTH-1:0]            INSTRUCTION,
    output logic [OPND_WIDTH-1:0]             OPERAND,
    output logic                              INSTR_VALID,
    input  logic [1:0]                        JUMP,
    input  logic                              CE_STACK,
    input  logic                              nRW_STACK,
    input  logic                              STACK_SEL,
    input  logic                              PC_SEL,
    input  logic                              RESET_INSTR,
    input  logic                              ZERO,
    input  logic                              STALL,
    output logic [ADDR_WIDTH-1:0]             PC,
    output logic                              STACK_ERR
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int IR_W  = INSTR_WIDTH + OPND_WIDTH;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        LOAD  = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;
    logic [SP_W-1:0]       sp_q;
    logic [SP_W-1:0]       sp_d;
    logic [IR_W-1:0]       ir_q;
    logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];

    logic                   ir_load;
    logic                   push;
    logic [INSTR_WIDTH-1:0] ir_op;
    logic [OPND_WIDTH-1:0]  ir_opnd;
    logic [ADDR_WIDTH-1:0]  opnd_addr;
    logic [ADDR_WIDTH-1:0]  pc_inc;
    logic [SP_W-1:0]        sp_dec;
    logic [IDX_W-1:0]       wr_idx;
    logic [IDX_W-1:0]       top_idx;
    logic [ADDR_WIDTH-1:0]  top;
    logic                   full;
    logic                   empty;
    logic                   is_call;
    logic                   is_ret;
    logic                   take_jump;
`ifdef STACK_OVF_TRAP_EN
    logic                   err_q;
    logic                   err_set;
`endif

    assign ir_op     = ir_q[IR_W-1 -: INSTR_WIDTH];
    assign ir_opnd   = ir_q[OPND_WIDTH-1:0];
    assign opnd_addr = ADDR_WIDTH'(ir_opnd);
    assign pc_inc    = pc_q + ADDR_WIDTH'(1);
    assign sp_dec    = sp_q - SP_W'(1);
    assign wr_idx    = sp_q[IDX_W-1:0];
    assign top_idx   = sp_dec[IDX_W-1:0];
    assign top       = stack_q[top_idx];
    assign full      = (sp_q == SP_W'(STACK_DEPTH));
    assign empty     = (sp_q == '0);
    assign is_call   = CE_STACK & nRW_STACK & STACK_SEL;
    assign is_ret    = CE_STACK & ~nRW_STACK & PC_SEL;
    assign take_jump = (JUMP == 2'b11)
                     | ((JUMP == 2'b01) & ZERO)
                     | ((JUMP == 2'b10) & ~ZERO);

    // Next state, next PC/SP and stack push decision
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        sp_d    = sp_q;
        ir_load = 1'b0;
        push    = 1'b0;
`ifdef STACK_OVF_TRAP_EN
        err_set = 1'b0;
`endif
        unique case (state_q)
            FETCH: state_d = LOAD;
            LOAD: begin
                state_d = EXEC;
                ir_load = 1'b1;
            end
            EXEC: begin
                if (!STALL) begin
                    state_d = FETCH;
                    if (!RESET_INSTR) begin
                        pc_d = '0;
                        sp_d = '0;
                    end else if (is_ret) begin
                        if (empty) begin
`ifdef STACK_OVF_TRAP_EN
                            err_set = 1'b1;
                            state_d = HALT;
`else
                            pc_d = '0;
`endif
                        end else begin
                            pc_d = top;
                            sp_d = sp_dec;
                        end
                    end else if (is_call) begin
                        if (full) begin
`ifdef STACK_OVF_TRAP_EN
                            err_set = 1'b1;
                            state_d = HALT;
`else
                            pc_d = opnd_addr;
`endif
                        end else begin
                            push = 1'b1;
                            pc_d = opnd_addr;
                            sp_d = sp_q + SP_W'(1);
                        end
                    end else if (take_jump) begin
                        pc_d = opnd_addr;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            HALT: state_d = HALT;
        endcase
    end

    // State, PC, SP, instruction register and stack storage
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= FETCH;
            pc_q    <= '0;
            sp_q    <= '0;
            ir_q    <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            if (ir_load) begin
                ir_q <= PROG_DATA;
            end
            if (push) begin
                stack_q[wr_idx] <= pc_inc;
            end
        end
    end

`ifdef STACK_OVF_TRAP_EN
    // Sticky stack fault, cleared only by reset
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign STACK_ERR = err_q;
`else
    assign STACK_ERR = 1'b0;
`endif

    // Memory interface and decoder-facing outputs
    always_comb begin
        PROG_ADDR   = pc_q;
        PC          = pc_q;
        PROG_RE     = (state_q == FETCH);
        INSTR_VALID = (state_q == EXEC);
        INSTRUCTION = '0;
        OPERAND     = '0;
        if (state_q == EXEC) begin
            INSTRUCTION = ir_op;
            OPERAND     = ir_opnd;
        end
    end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed testbench for program_sequencer.
// Covers both STACK_OVF_TRAP_EN builds.
module tb_program_sequencer;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [7:0]  PROG_ADDR;
    logic        PROG_RE;
    logic [12:0] PROG_DATA = '0;
    logic [4:0]  INSTRUCTION;
    logic [7:0]  OPERAND;
    logic        INSTR_VALID;
    logic [1:0]  JUMP = 2'b00;
    logic        CE_STACK = 1'b0;
    logic        nRW_STACK = 1'b0;
    logic        STACK_SEL = 1'b0;
    logic        PC_SEL = 1'b0;
    logic        RESET_INSTR = 1'b1;
    logic        ZERO = 1'b0;
    logic        STALL = 1'b0;
    logic [7:0]  PC;
    logic        STACK_ERR;

    program_sequencer dut (
        .CLK(CLK), .nRST(nRST),
        .PROG_ADDR(PROG_ADDR), .PROG_RE(PROG_RE),
        .PROG_DATA(PROG_DATA),
        .INSTRUCTION(INSTRUCTION), .OPERAND(OPERAND),
        .INSTR_VALID(INSTR_VALID),
        .JUMP(JUMP), .CE_STACK(CE_STACK),
        .nRW_STACK(nRW_STACK), .STACK_SEL(STACK_SEL),
        .PC_SEL(PC_SEL), .RESET_INSTR(RESET_INSTR),
        .ZERO(ZERO), .STALL(STALL),
        .PC(PC), .STACK_ERR(STACK_ERR)
    );

    always #5 CLK = ~CLK;

    logic [12:0] mem [256];

    always @(posedge CLK) begin
        if (PROG_RE) PROG_DATA <= mem[PROG_ADDR];
    end

    typedef struct {
        logic [4:0] op;
        logic [7:0] opnd;
        logic [1:0] jump;
        logic       ce, nrw, ssel, psel, rsti, zero;
        int         stall;
        logic [7:0] exp_pc;
        logic       halt;
    } vec_t;

    int         n_total = 0;
    int         n_pass  = 0;
    logic [7:0] cur_pc  = '0;
    vec_t       tbl[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(
        input logic [4:0] op, input logic [7:0] opnd,
        input logic [1:0] jump, input logic ce, input logic nrw,
        input logic ssel, input logic psel, input logic rsti,
        input logic zero, input int stall, input logic [7:0] exp_pc,
        input logic halt);
        vec_t v;
        v.op = op; v.opnd = opnd; v.jump = jump;
        v.ce = ce; v.nrw = nrw; v.ssel = ssel; v.psel = psel;
        v.rsti = rsti; v.zero = zero; v.stall = stall;
        v.exp_pc = exp_pc; v.halt = halt;
        return v;
    endfunction

    task automatic idle_dec();
        JUMP = 2'b00; CE_STACK = 1'b0; nRW_STACK = 1'b0;
        STACK_SEL = 1'b0; PC_SEL = 1'b0; RESET_INSTR = 1'b1;
        ZERO = 1'b0; STALL = 1'b0;
    endtask

    task automatic do_reset();
        idle_dec();
        nRST = 1'b0;
        #1;
        chk("rst_pc", PC, 8'h00);
        chk("rst_re", PROG_RE, 1'b1);
        chk("rst_valid", INSTR_VALID, 1'b0);
        chk("rst_err", STACK_ERR, 1'b0);
        @(negedge CLK);
        nRST = 1'b1;
        cur_pc = 8'h00;
    endtask

    // Runs one instruction, entered and left at a FETCH negedge
    task automatic do_instr(input vec_t v);
        chk("fetch_re", PROG_RE, 1'b1);
        chk("fetch_addr", PROG_ADDR, cur_pc);
        chk("fetch_valid", INSTR_VALID, 1'b0);
        mem[cur_pc] = {v.op, v.opnd};
        @(negedge CLK);
        chk("load_re", PROG_RE, 1'b0);
        chk("load_valid", INSTR_VALID, 1'b0);
        chk("load_instr", INSTRUCTION, 5'h00);
        chk("load_opnd", OPERAND, 8'h00);
        @(negedge CLK);
        chk("exec_valid", INSTR_VALID, 1'b1);
        chk("exec_instr", INSTRUCTION, v.op);
        chk("exec_opnd", OPERAND, v.opnd);
        JUMP = v.jump; CE_STACK = v.ce; nRW_STACK = v.nrw;
        STACK_SEL = v.ssel; PC_SEL = v.psel;
        RESET_INSTR = v.rsti; ZERO = v.zero;
        STALL = (v.stall > 0);
        for (int i = 0; i < v.stall; i++) begin
            @(negedge CLK);
            chk("stall_valid", INSTR_VALID, 1'b1);
            chk("stall_pc", PC, cur_pc);
        end
        STALL = 1'b0;
        @(negedge CLK);
        idle_dec();
        cur_pc = v.exp_pc;
        chk("next_pc", PC, cur_pc);
        chk("stack_err", STACK_ERR, v.halt);
        if (v.halt) begin
            for (int i = 0; i < 3; i++) begin
                chk("halt_re", PROG_RE, 1'b0);
                chk("halt_valid", INSTR_VALID, 1'b0);
                chk("halt_instr", INSTRUCTION, 5'h00);
                chk("halt_pc", PC, cur_pc);
                @(negedge CLK);
            end
        end
    endtask

    task automatic run_tbl();
        foreach (tbl[i]) do_instr(tbl[i]);
        tbl.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        @(negedge CLK);
        do_reset();

        //          op     opnd   jmp  ce nrw ss ps rs z  st exp    h
        tbl.push_back(mk(5'h00, 8'h00, 2'b00, 0,0,0,0,1,0, 0, 8'h01, 0));
        tbl.push_back(mk(5'h00, 8'h00, 2'b00, 0,0,0,0,1,0, 0, 8'h02, 0));
        tbl.push_back(mk(5'h00, 8'h00, 2'b00, 0,0,0,0,1,0, 0, 8'h03, 0));
        tbl.push_back(mk(5'h01, 8'h40, 2'b01, 0,0,0,0,1,1, 0, 8'h40, 0));
        tbl.push_back(mk(5'h01, 8'h20, 2'b01, 0,0,0,0,1,0, 0, 8'h41, 0));
        tbl.push_back(mk(5'h02, 8'h10, 2'b10, 0,0,0,0,1,0, 0, 8'h10, 0));
        tbl.push_back(mk(5'h03, 8'h80, 2'b00, 1,1,1,0,1,0, 0, 8'h80, 0));
        tbl.push_back(mk(5'h04, 8'h00, 2'b00, 1,0,0,1,1,0, 0, 8'h11, 0));
        tbl.push_back(mk(5'h02, 8'h30, 2'b10, 0,0,0,0,1,1, 0, 8'h12, 0));
        tbl.push_back(mk(5'h05, 8'h77, 2'b00, 1,1,0,1,1,0, 0, 8'h13, 0));
        tbl.push_back(mk(5'h00, 8'h00, 2'b00, 0,0,0,0,1,0, 5, 8'h14, 0));
        tbl.push_back(mk(5'h06, 8'hFF, 2'b11, 0,0,0,0,1,0, 0, 8'hFF, 0));
        tbl.push_back(mk(5'h00, 8'h00, 2'b00, 0,0,0,0,1,0, 0, 8'h00, 0));
        tbl.push_back(mk(5'h03, 8'hFF, 2'b00, 1,1,1,0,1,0, 0, 8'hFF, 0));
        tbl.push_back(mk(5'h03, 8'h50, 2'b00, 1,1,1,0,1,0, 0, 8'h50, 0));
        tbl.push_back(mk(5'h07, 8'h00, 2'b00, 0,0,0,0,0,0, 0, 8'h00, 0));
        tbl.push_back(mk(5'h03, 8'h60, 2'b00, 1,1,1,0,1,0, 0, 8'h60, 0));
        tbl.push_back(mk(5'h03, 8'h70, 2'b11, 1,1,1,0,1,0, 0, 8'h70, 0));
        tbl.push_back(mk(5'h04, 8'h33, 2'b11, 1,0,0,1,1,0, 0, 8'h61, 0));
        tbl.push_back(mk(5'h04, 8'h00, 2'b00, 1,0,0,1,1,0, 0, 8'h01, 0));
        tbl.push_back(mk(5'h03, 8'h90, 2'b00, 1,1,1,0,1,0, 0, 8'h90, 0));
        tbl.push_back(mk(5'h04, 8'h00, 2'b00, 1,0,0,1,0,0, 0, 8'h00, 0));
        tbl.push_back(mk(5'h06, 8'h40, 2'b11, 0,0,0,0,1,0, 0, 8'h40, 0));
        run_tbl();

        // nRST pulse while a CALL sits in LOAD
        mem[cur_pc] = {5'h03, 8'h80};
        @(negedge CLK);
        chk("pulse_in_load", PROG_RE, 1'b0);
        nRST = 1'b0;
        #1;
        chk("pulse_pc", PC, 8'h00);
        chk("pulse_re", PROG_RE, 1'b1);
        chk("pulse_valid", INSTR_VALID, 1'b0);
        @(negedge CLK);
        nRST = 1'b1;
        cur_pc = 8'h00;
        tbl.push_back(mk(5'h00, 8'h00, 2'b00, 0,0,0,0,1,0, 0, 8'h01, 0));
        run_tbl();

        // Five nested CALLs on a 4-deep stack
        do_reset();
        tbl.push_back(mk(5'h03, 8'h10, 2'b00, 1,1,1,0,1,0, 0, 8'h10, 0));
        tbl.push_back(mk(5'h03, 8'h20, 2'b00, 1,1,1,0,1,0, 0, 8'h20, 0));
        tbl.push_back(mk(5'h03, 8'h30, 2'b00, 1,1,1,0,1,0, 0, 8'h30, 0));
        tbl.push_back(mk(5'h03, 8'h40, 2'b00, 1,1,1,0,1,0, 0, 8'h40, 0));
`ifdef STACK_OVF_TRAP_EN
        tbl.push_back(mk(5'h03, 8'h50, 2'b00, 1,1,1,0,1,0, 0, 8'h40, 1));
        run_tbl();
        do_reset();
        tbl.push_back(mk(5'h04, 8'h00, 2'b00, 1,0,0,1,1,0, 0, 8'h00, 1));
        run_tbl();
        do_reset();
`else
        tbl.push_back(mk(5'h03, 8'h50, 2'b00, 1,1,1,0,1,0, 0, 8'h50, 0));
        tbl.push_back(mk(5'h04, 8'h00, 2'b00, 1,0,0,1,1,0, 0, 8'h31, 0));
        tbl.push_back(mk(5'h04, 8'h00, 2'b00, 1,0,0,1,1,0, 0, 8'h21, 0));
        tbl.push_back(mk(5'h04, 8'h00, 2'b00, 1,0,0,1,1,0, 0, 8'h11, 0));
        tbl.push_back(mk(5'h04, 8'h00, 2'b00, 1,0,0,1,1,0, 0, 8'h01, 0));
        tbl.push_back(mk(5'h04, 8'h00, 2'b00, 1,0,0,1,1,0, 0, 8'h00, 0));
        tbl.push_back(mk(5'h00, 8'h00, 2'b00, 0,0,0,0,1,0, 0, 8'h01, 0));
`endif
        run_tbl();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, program address width.
REQ-002 SHALL have parameter INSTR_WIDTH, default 5, opcode width.
REQ-003 SHALL have parameter OPND_WIDTH, default 8, operand width (= ADDR_WIDTH).
REQ-004 SHALL have parameter STACK_DEPTH, default 4, return-address stack entries.
REQ-005 SHALL use one clock and an asynchronous active-low reset: CLK  in  1  rising-edge clock.
REQ-006 nRST  in  1  asynchronous active-low reset.
REQ-007 PROG_ADDR  out  ADDR_WIDTH  program memory address.
REQ-008 PROG_RE  out  1  program memory read enable.
REQ-009 PROG_DATA  in  INSTR_WIDTH+OPND_WIDTH  read word, valid 1 cycle after PROG_RE; [MSBs] opcode, [LSBs] operand.
REQ-010 INSTRUCTION  out  INSTR_WIDTH  opcode to instruction_decoder.
REQ-011 OPERAND  out  OPND_WIDTH  operand/immediate/jump target.
REQ-012 INSTR_VALID  out  1  high while in EXEC.
REQ-013 JUMP  in  2  from decoder: 00 none, 01 jump if ZERO, 10 jump if !ZERO, 11 unconditional.
REQ-014 CE_STACK, nRW_STACK, STACK_SEL, PC_SEL  in  1 each  from decoder.
REQ-015 RESET_INSTR  in  1  from decoder, active-low software reset request.
REQ-016 ZERO  in  1  accumulator zero flag.
REQ-017 STALL  in  1  holds EXEC.
REQ-018 PC  out  ADDR_WIDTH  current program counter.
REQ-019 STACK_ERR  out  1  sticky stack fault.

Function
REQ-020 FSM states SHALL be FETCH, LOAD, EXEC, HALT; FETCH->LOAD->EXEC unconditional.
REQ-021 FETCH SHALL drive PROG_RE=1, PROG_ADDR=PC; PROG_RE=0 in all other states.
REQ-022 LOAD SHALL capture PROG_DATA into instruction register IR.
REQ-023 INSTRUCTION/OPERAND SHALL show IR only in EXEC; otherwise INSTRUCTION=5'h00 (NOP), OPERAND=0.
REQ-024 EXEC SHALL hold while STALL=1; at the EXEC edge with STALL=0 SHALL update PC and go to FETCH (3 cycles/instruction minimum).
REQ-025 CALL = CE_STACK & nRW_STACK & STACK_SEL; RET = CE_STACK & !nRW_STACK & PC_SEL; other stack accesses SHALL be ignored.
REQ-026 PC update priority at EXEC exit: RESET_INSTR=0 -> PC=0, SP=0; else RET -> PC=top, pop; else CALL -> push PC+1, PC=OPERAND; else JUMP=11, JUMP=01&ZERO, or JUMP=10&!ZERO -> PC=OPERAND; else PC=PC+1.
REQ-027 PC+1 SHALL wrap 2^ADDR_WIDTH-1 -> 0; pushed return address wraps likewise.
REQ-028 Stack pointer SP SHALL range 0..STACK_DEPTH; full at STACK_DEPTH, empty at 0.
REQ-029 HALT SHALL be absorbing; INSTR_VALID=0, INSTRUCTION=NOP; exit only via nRST.

Reset
REQ-030 nRST=0 SHALL immediately set state=FETCH, PC=0, SP=0, IR=0, STACK_ERR=0, all stack entries=0.
REQ-031 nRST asserted mid-instruction SHALL abort it with no PC/stack update.
REQ-032 On nRST release the first FETCH SHALL read address 0.

Configuration
REQ-033 Macro STACK_OVF_TRAP_EN defined: CALL when full or RET when empty SHALL set STACK_ERR=1 and enter HALT without PC/SP change.
REQ-034 Macro undefined: CALL when full SHALL jump without pushing; RET when empty SHALL set PC=0; STACK_ERR tied 0; no HALT state reachable.

Verification
REQ-035 Reset release, memory 0x00..0x02 = NOP -> PROG_ADDR 0,1,2 on FETCH cycles; INSTR_VALID every 3rd cycle.
REQ-036 EXEC with JUMP=01, OPERAND=0x40: ZERO=1 -> PC=0x40; ZERO=0 -> PC=PC+1; JUMP=10 inverse.
REQ-037 CALL 0x80 at PC=0x10, then RET -> PC=0x80 then 0x11; SP 0->1->0.
REQ-038 STACK_DEPTH=4, five nested CALLs -> with STACK_OVF_TRAP_EN STACK_ERR=1 and HALT; without, fifth jumps and SP stays 4.
REQ-039 PC=0xFF, NOP -> PC=0x00; STALL=1 for 5 cycles in EXEC -> PC unchanged, INSTR_VALID held high.
REQ-040 RESET_INSTR=0 in EXEC with SP=2 -> PC=0, SP=0; nRST pulse during LOAD -> PC=0, next FETCH address 0.
